systolic_skew_feeder: RTL

//  Upstream edge feeder for an N x N array of PE (MAC) tiles. Accepts one K-step job
//  of N-lane A and B vectors over a valid/ready stream and drives the array's west (A) and

---
 rtl/systolic_skew_feeder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for an N x N systolic MAC array: accepts one K-beat job of A/B lane
// vectors and drives them diagonally skewed onto the array edges, plus PE enable and done.
module systolic_skew_feeder #(
    parameter int W     = 16,
    parameter int N     = 4,
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N*W-1:0]   i_a,
    input  logic [N*W-1:0]   i_b,
    output logic [N*W-1:0]   o_a,
    output logic [N*W-1:0]   o_b,
    output logic             o_pe_en,
    output logic             o_busy,
    output logic             o_done
);

    localparam int FLUSH_CYC = 2 * N;
    localparam int FLUSH_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic               pe_en_q, pe_en_d;
    logic               done_q, done_d;
    logic               accept;

    assign accept = (state_q == S_FEED) && i_valid;

    // A start coinciding with the done pulse is ignored; the next cycle may start a job.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pe_en_d     = pe_en_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start && (i_len != '0) && !done_q) begin
                    state_d    = S_CLEAR;
                    len_d      = i_len;
                    beat_cnt_d = '0;
                    pe_en_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                pe_en_d = 1'b1;
            end
            S_FEED: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == len_q - 1'b1) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == FLUSH_W'(FLUSH_CYC - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            pe_en_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            pe_en_q     <= pe_en_d;
            done_q      <= done_d;
        end
    end

    assign o_ready = (state_q == S_FEED);
    assign o_busy  = (state_q != S_IDLE);
    assign o_pe_en = pe_en_q;
    assign o_done  = done_q;

    // Lane r is a chain of r+1 registers; non-accept cycles push zero bubbles.
    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [W-1:0] a_pipe_q [r+1];
        logic [W-1:0] a_pipe_d [r+1];
        logic [W-1:0] b_pipe_q [r+1];
        logic [W-1:0] b_pipe_d [r+1];

        always_comb begin
            a_pipe_d[0] = accept ? i_a[r*W +: W] : '0;
            b_pipe_d[0] = accept ? i_b[r*W +: W] : '0;
            for (int s = 1; s <= r; s++) begin
                a_pipe_d[s] = a_pipe_q[s-1];
                b_pipe_d[s] = b_pipe_q[s-1];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int s = 0; s <= r; s++) begin
                    a_pipe_q[s] <= '0;
                    b_pipe_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s <= r; s++) begin
                    a_pipe_q[s] <= a_pipe_d[s];
                    b_pipe_q[s] <= b_pipe_d[s];
                end
            end
        end

        assign o_a[r*W +: W] = a_pipe_q[r];
        assign o_b[r*W +: W] = b_pipe_q[r];
    end

endmodule
